fht_frame_sched: RTL and testbench
==================================

// Module: fht_frame_sched
// PURPOSE
//  Frame-level scheduler around the FHT core (fht_control + butterfly datapath + RAM).
//  Manages two frame buffers (ping/pong) so input loading, FHT processing and output
//  unloading overlap. Generates load/unload RAM addresses and the iSTART pulse to
//  fht_control; frames are processed and emitted strictly in arrival order.
// PARAMETERS
//  N_BIT    11  log2 frame length (N = 2**N_BIT points per frame)
//  RD_LAT   2   RAM read latency in cycles (unload data valid delay)
//  RDY_TO   4   max cycles from oFHT_START to iFHT_RDY falling before oERR is set
// PORTS
//  iCLK          in   1      clock, all logic on rising edge
//  iRESET        in   1      synchronous reset, active-high
//  iIN_VALID     in   1      input sample present
//  oIN_READY     out  1      loader can accept a sample this cycle
//  oLOAD_WE      out  1      write strobe to frame RAM (= iIN_VALID & oIN_READY)
//  oLOAD_BANK    out  1      buffer being loaded (0=A,1=B)
//  oLOAD_ADDR    out  N_BIT  write address, 0..N-1 natural order
//  oFHT_START    out  1      1-cycle start pulse to fht_control.iSTART
//  oFHT_BANK     out  1      buffer owned by FHT core
//  iFHT_RDY      in   1      fht_control.oRDY (1 = idle)
//  iOUT_READY    in   1      downstream can take a read this cycle
//  oRD_EN        out  1      RAM read strobe for unload
//  oUNLOAD_BANK  out  1      buffer being unloaded
//  oUNLOAD_ADDR  out  N_BIT  read address, 0..N-1
//  oOUT_VALID    out  1      oRD_EN delayed RD_LAT cycles (data valid at RAM output)
//  oOUT_LAST     out  1      with oOUT_VALID on sample N-1 of a frame
//  oERR          out  1      sticky: iFHT_RDY not seen low within RDY_TO after start
// BEHAVIOUR
//  Reset: both buffers EMPTY, load/fht/unload pointers = 0, all outputs 0, oERR cleared.
//  Per-buffer state: EMPTY -> FILLING -> FULL -> FHT -> DONE -> UNLOAD -> EMPTY.
//  Loader: oIN_READY=1 iff buffer[load_ptr] is EMPTY or FILLING. Each accepted sample
//   writes oLOAD_ADDR then increments; on write of addr N-1: buffer->FULL, addr wraps 0,
//   load_ptr toggles, all in same edge. No sample is dropped; backpressure only.
//  Core FSM: IDLE -> (buffer[fht_ptr]==FULL & iFHT_RDY) -> START (oFHT_START=1 one cycle,
//   buffer->FHT) -> WAIT_LOW (iFHT_RDY==0) -> WAIT_HIGH (iFHT_RDY==1) -> buffer->DONE,
//   fht_ptr toggles -> IDLE. WAIT_LOW counts cycles; count reaching RDY_TO sets oERR and
//   FSM stays in WAIT_LOW (no further starts) until reset.
//  FULL is registered: earliest oFHT_START is 1 cycle after the last load write.
//  Unloader: active when buffer[unload_ptr]==DONE/UNLOAD; oRD_EN = active & iOUT_READY;
//   address increments per oRD_EN; on read of N-1: buffer->EMPTY, unload_ptr toggles.
//   oOUT_VALID/oOUT_LAST come from an RD_LAT-deep shift line; downstream must absorb
//   RD_LAT in-flight samples after dropping iOUT_READY.
//  Buffer freed by unload is usable by loader next cycle (registered state).
//  Simultaneous transitions on different buffers in one cycle are all honoured; one
//   buffer is never owned by two stages (guaranteed by the state encoding).
//  Reset mid-operation discards all frames; fht_control must share iRESET.
//  oFHT_BANK/oLOAD_BANK/oUNLOAD_BANK hold pointer values at all times (0 after reset).
// STRUCTURE
//  fht_sched_pkg: buf_state_t enum (EMPTY..UNLOAD), core_state_t enum
//   (IDLE,START,WAIT_LOW,WAIT_HIGH), BANK_A/BANK_B constants.
//  Sub-module fht_sched_unload: unload address counter + RD_LAT valid/last delay line.
//  Loader, core FSM and buffer-state registers stay in the top.
// TESTING (N_BIT=4 for sim speed, RD_LAT=2; core model drops RDY 1 cycle after start,
//  raises after 20)
//  1 reset: after iRESET, oIN_READY=1, oLOAD_ADDR=0, oFHT_START=0, oERR=0, banks=0.
//  2 single frame: 16 valid samples -> oFHT_START exactly 1 cycle after 16th write, bank 0;
//    after RDY rises, 16 oRD_EN addr 0..15, oOUT_LAST with 16th oOUT_VALID, RD_LAT later.
//  3 streaming: continuous iIN_VALID, iOUT_READY=1 -> loads alternate banks 0,1,0; no
//    backpressure until both buffers occupied; output frame order matches input order.
//  4 backpressure: iOUT_READY=0 holding 2 frames -> oIN_READY=0 on 1st sample of 3rd
//    frame; release -> loading resumes at addr 0 of freed bank, no sample lost/duplicated.
//  5 timeout: core model never drops RDY -> oERR=1 at RDY_TO cycles after start, no
//    second oFHT_START; iRESET clears oERR.
//  6 reset mid-FHT: assert iRESET during WAIT_HIGH -> all buffers EMPTY, outputs 0, next
//    frame starts at bank 0 addr 0.

Source files
------------

// File: rtl/fht_sched_pkg.sv
// Shared types for the FHT frame scheduler: per-buffer ownership states,
// core handshake FSM states and bank identifiers.
package fht_sched_pkg;

  typedef enum logic [2:0] {
    BUF_EMPTY,
    BUF_FILLING,
    BUF_FULL,
    BUF_FHT,
    BUF_DONE,
    BUF_UNLOAD
  } buf_state_t;

  typedef enum logic [1:0] {
    CORE_IDLE,
    CORE_START,
    CORE_WAIT_LOW,
    CORE_WAIT_HIGH
  } core_state_t;

  localparam logic BANK_A = 1'b0;
  localparam logic BANK_B = 1'b1;

  function automatic logic next_bank(input logic bank);
    return (bank == BANK_A) ? BANK_B : BANK_A;
  endfunction

endpackage

// File: rtl/fht_sched_unload.sv
// Unload side of the frame scheduler: read address counter plus an RD_LAT-deep
// delay line that realigns valid/last with data emerging from the RAM.
module fht_sched_unload
  import fht_sched_pkg::*;
#(
  parameter int N_BIT  = 11,
  parameter int RD_LAT = 2
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             i_active,
  input  logic             i_out_ready,
  output logic             o_rd_en,
  output logic [N_BIT-1:0] o_addr,
  output logic             o_rd_last,
  output logic             o_out_valid,
  output logic             o_out_last
);

  localparam logic [N_BIT-1:0] ADDR_ONE  = N_BIT'(1);
  localparam logic [N_BIT-1:0] ADDR_LAST = '1;

  logic [N_BIT-1:0]  r_addr;
  logic [RD_LAT-1:0] r_vld_line;
  logic [RD_LAT-1:0] r_last_line;
  logic              w_rd_en;
  logic              w_rd_last;

  assign w_rd_en     = i_active & i_out_ready;
  assign w_rd_last   = w_rd_en & (r_addr == ADDR_LAST);
  assign o_rd_en     = w_rd_en;
  assign o_addr      = r_addr;
  assign o_rd_last   = w_rd_last;
  assign o_out_valid = r_vld_line[RD_LAT-1];
  assign o_out_last  = r_last_line[RD_LAT-1];

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      r_addr      <= '0;
      r_vld_line  <= '0;
      r_last_line <= '0;
    end else begin
      if (w_rd_en) r_addr <= r_addr + ADDR_ONE;
      // stage 0 of the read-latency line; later stages just follow
      r_vld_line[0]  <= w_rd_en;
      r_last_line[0] <= w_rd_last;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld_line[i]  <= r_vld_line[i-1];
        r_last_line[i] <= r_last_line[i-1];
      end
    end
  end

endmodule

// File: rtl/fht_frame_sched.sv
// Ping/pong frame scheduler around the FHT core: loader, core start/handshake
// FSM and buffer ownership live here; the unloader is a sub-module.
module fht_frame_sched
  import fht_sched_pkg::*;
#(
  parameter int N_BIT  = 11,
  parameter int RD_LAT = 2,
  parameter int RDY_TO = 4
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iIN_VALID,
  output logic             oIN_READY,
  output logic             oLOAD_WE,
  output logic             oLOAD_BANK,
  output logic [N_BIT-1:0] oLOAD_ADDR,
  output logic             oFHT_START,
  output logic             oFHT_BANK,
  input  logic             iFHT_RDY,
  input  logic             iOUT_READY,
  output logic             oRD_EN,
  output logic             oUNLOAD_BANK,
  output logic [N_BIT-1:0] oUNLOAD_ADDR,
  output logic             oOUT_VALID,
  output logic             oOUT_LAST,
  output logic             oERR
);

  localparam int               CW        = $clog2(RDY_TO + 1);
  localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]    CNT_LAST  = CW'(RDY_TO - 1);
  localparam logic [N_BIT-1:0] ADDR_ONE  = N_BIT'(1);
  localparam logic [N_BIT-1:0] ADDR_LAST = '1;

  buf_state_t       r_buf [0:1];
  core_state_t      r_core;
  logic             r_load_ptr;
  logic             r_fht_ptr;
  logic             r_unload_ptr;
  logic [N_BIT-1:0] r_load_addr;
  logic [CW-1:0]    r_cnt;
  logic             r_fht_start;
  logic             r_err;

  logic w_load_we;
  logic w_unl_active;
  logic w_rd_en;
  logic w_rd_last;

  assign oIN_READY    = (r_buf[r_load_ptr] == BUF_EMPTY) || (r_buf[r_load_ptr] == BUF_FILLING);
  assign w_load_we    = iIN_VALID & oIN_READY;
  assign w_unl_active = (r_buf[r_unload_ptr] == BUF_DONE) || (r_buf[r_unload_ptr] == BUF_UNLOAD);

  assign oLOAD_WE     = w_load_we;
  assign oLOAD_BANK   = r_load_ptr;
  assign oLOAD_ADDR   = r_load_addr;
  assign oFHT_START   = r_fht_start;
  assign oFHT_BANK    = r_fht_ptr;
  assign oUNLOAD_BANK = r_unload_ptr;
  assign oRD_EN       = w_rd_en;
  assign oERR         = r_err;

  fht_sched_unload #(
    .N_BIT  (N_BIT),
    .RD_LAT (RD_LAT)
  ) u_unload (
    .iCLK        (iCLK),
    .iRESET      (iRESET),
    .i_active    (w_unl_active),
    .i_out_ready (iOUT_READY),
    .o_rd_en     (w_rd_en),
    .o_addr      (oUNLOAD_ADDR),
    .o_rd_last   (w_rd_last),
    .o_out_valid (oOUT_VALID),
    .o_out_last  (oOUT_LAST)
  );

  // Each stage only ever touches the buffer its own pointer names, and the
  // state encoding keeps those pointers on distinct buffers when both act.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      r_buf[0]     <= BUF_EMPTY;
      r_buf[1]     <= BUF_EMPTY;
      r_core       <= CORE_IDLE;
      r_load_ptr   <= BANK_A;
      r_fht_ptr    <= BANK_A;
      r_unload_ptr <= BANK_A;
      r_load_addr  <= '0;
      r_cnt        <= '0;
      r_fht_start  <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_fht_start <= 1'b0;

      if (w_load_we) begin
        r_load_addr <= r_load_addr + ADDR_ONE;
        if (r_load_addr == ADDR_LAST) begin
          r_buf[r_load_ptr] <= BUF_FULL;
          r_load_ptr        <= next_bank(r_load_ptr);
        end else begin
          r_buf[r_load_ptr] <= BUF_FILLING;
        end
      end

      case (r_core)
        CORE_IDLE: begin
          if ((r_buf[r_fht_ptr] == BUF_FULL) && iFHT_RDY) begin
            r_buf[r_fht_ptr] <= BUF_FHT;
            r_fht_start      <= 1'b1;
            r_core           <= CORE_START;
          end
        end
        CORE_START: begin
          r_cnt  <= CNT_ONE;
          r_core <= CORE_WAIT_LOW;
        end
        CORE_WAIT_LOW: begin
          // once the core has timed out we park here until reset
          if (!r_err) begin
            if (!iFHT_RDY)             r_core <= CORE_WAIT_HIGH;
            else if (r_cnt == CNT_LAST) r_err <= 1'b1;
            else                        r_cnt <= r_cnt + CNT_ONE;
          end
        end
        CORE_WAIT_HIGH: begin
          if (iFHT_RDY) begin
            r_buf[r_fht_ptr] <= BUF_DONE;
            r_fht_ptr        <= next_bank(r_fht_ptr);
            r_core           <= CORE_IDLE;
          end
        end
        default: r_core <= CORE_IDLE;
      endcase

      if (w_rd_last) begin
        r_buf[r_unload_ptr] <= BUF_EMPTY;
        r_unload_ptr        <= next_bank(r_unload_ptr);
      end else if (w_rd_en) begin
        r_buf[r_unload_ptr] <= BUF_UNLOAD;
      end
    end
  end

endmodule

// File: tb/tb_fht_frame_sched.sv
// Bench for fht_frame_sched: frame-count reference model plus a behavioural
// fht_control stand-in (RDY low one cycle after start, back high after 20).
module tb_fht_frame_sched;

  localparam int NB      = 4;
  localparam int NPT     = 1 << NB;
  localparam int LAT     = 2;
  localparam int TO      = 4;
  localparam int FHT_CYC = 20;

  logic          iCLK, iRESET, iIN_VALID, iFHT_RDY, iOUT_READY;
  logic          oIN_READY, oLOAD_WE, oLOAD_BANK, oFHT_START, oFHT_BANK;
  logic          oRD_EN, oUNLOAD_BANK, oOUT_VALID, oOUT_LAST, oERR;
  logic [NB-1:0] oLOAD_ADDR, oUNLOAD_ADDR;

  fht_frame_sched #(.N_BIT(NB), .RD_LAT(LAT), .RDY_TO(TO)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iIN_VALID(iIN_VALID), .oIN_READY(oIN_READY),
    .oLOAD_WE(oLOAD_WE), .oLOAD_BANK(oLOAD_BANK), .oLOAD_ADDR(oLOAD_ADDR),
    .oFHT_START(oFHT_START), .oFHT_BANK(oFHT_BANK), .iFHT_RDY(iFHT_RDY),
    .iOUT_READY(iOUT_READY), .oRD_EN(oRD_EN), .oUNLOAD_BANK(oUNLOAD_BANK),
    .oUNLOAD_ADDR(oUNLOAD_ADDR), .oOUT_VALID(oOUT_VALID), .oOUT_LAST(oOUT_LAST),
    .oERR(oERR)
  );

  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  int n_chk = 0, n_pass = 0, cyc = 0;
  bit v_rst = 1'b1, v_in = 1'b0, v_ordy = 1'b0, normal_core = 1'b1;
  int n_wr, n_rd, n_start, n_done, tcnt;
  bit m_rdy = 1'b1;
  bit rd_d1, rd_d2, last_d1, last_d2;

  logic          e_ready, e_we, e_rd, e_rd_last, e_vld, e_last, e_ld_bank, e_rd_bank, e_st_bank, e_st_ok;
  logic [NB-1:0] e_ld_addr, e_rd_addr;

  // One clock: drive inputs at negedge, sample at negedge+1, derive the
  // expectations for this cycle, then advance the frame-count model.
  task automatic tick();
    @(negedge iCLK);
    iRESET = v_rst; iIN_VALID = v_in; iOUT_READY = v_ordy; iFHT_RDY = m_rdy;
    #1;
    cyc++;
    e_ready   = ((n_wr / NPT) - (n_rd / NPT)) < 2;
    e_we      = v_in && e_ready;
    e_ld_bank = 1'((n_wr / NPT) % 2);
    e_ld_addr = NB'(n_wr % NPT);
    e_rd      = v_ordy && ((n_rd / NPT) < n_done);
    e_rd_bank = 1'((n_rd / NPT) % 2);
    e_rd_addr = NB'(n_rd % NPT);
    e_rd_last = (n_rd % NPT) == NPT - 1;
    e_vld     = rd_d2;
    e_last    = last_d2;
    e_st_bank = 1'(n_start % 2);
    e_st_ok   = n_start < (n_wr / NPT);
    if (v_rst) begin
      n_wr = 0; n_rd = 0; n_start = 0; n_done = 0; tcnt = 0; m_rdy = 1'b1;
      rd_d1 = 0; rd_d2 = 0; last_d1 = 0; last_d2 = 0;
    end else begin
      rd_d2 = rd_d1; last_d2 = last_d1;
      rd_d1 = e_rd;  last_d1 = e_rd && e_rd_last;
      if (e_we) n_wr++;
      if (e_rd) n_rd++;
      if (oFHT_START === 1'b1) begin
        n_start++; tcnt = 1;
      end else if (normal_core && tcnt == FHT_CYC + 1) begin
        n_done++; tcnt = 0;
      end else if (tcnt > 0) begin
        tcnt++;
      end
      m_rdy = !(normal_core && tcnt >= 1 && tcnt <= FHT_CYC);
    end
  endtask

  task automatic do_reset();
    v_rst = 1'b1; v_in = 1'b0; v_ordy = 1'b0;
    tick();
    v_rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    n_chk++; if (oIN_READY !== 1'b1) $display("FAIL reset_ready got=%b exp=1", oIN_READY); else n_pass++;
    n_chk++; if (oLOAD_ADDR !== '0) $display("FAIL reset_load_addr got=%0d exp=0", oLOAD_ADDR); else n_pass++;
    n_chk++; if (oFHT_START !== 1'b0) $display("FAIL reset_start got=%b exp=0", oFHT_START); else n_pass++;
    n_chk++; if (oERR !== 1'b0) $display("FAIL reset_err got=%b exp=0", oERR); else n_pass++;
    n_chk++; if ({oLOAD_BANK, oFHT_BANK, oUNLOAD_BANK} !== 3'b000)
      $display("FAIL reset_banks got=%b exp=000", {oLOAD_BANK, oFHT_BANK, oUNLOAD_BANK}); else n_pass++;
    n_chk++; if ({oRD_EN, oOUT_VALID, oOUT_LAST, oLOAD_WE} !== 4'b0000)
      $display("FAIL reset_strobes got=%b exp=0000", {oRD_EN, oOUT_VALID, oOUT_LAST, oLOAD_WE}); else n_pass++;
  endtask

  task automatic test_single_frame();
    int nw = 0, nr = 0, nv = 0, w = -1, s = -1, r0 = -1, lastv = -1, starts = 0;
    do_reset();
    v_in = 1'b1; v_ordy = 1'b1;
    for (int i = 0; i < 150 && lastv < 0; i++) begin
      tick();
      if (oLOAD_WE === 1'b1) begin
        n_chk++;
        if ({oLOAD_BANK, oLOAD_ADDR} !== {1'b0, NB'(nw)})
          $display("FAIL single_load got=%b/%0d exp=0/%0d", oLOAD_BANK, oLOAD_ADDR, nw); else n_pass++;
        nw++;
        if (nw == NPT) begin w = cyc; v_in = 1'b0; end
      end
      if (oFHT_START === 1'b1) begin
        starts++;
        if (s < 0) s = cyc;
        n_chk++; if (oFHT_BANK !== 1'b0) $display("FAIL single_start_bank got=%b exp=0", oFHT_BANK); else n_pass++;
      end
      if (oRD_EN === 1'b1) begin
        if (r0 < 0) r0 = cyc;
        n_chk++;
        if ({oUNLOAD_BANK, oUNLOAD_ADDR} !== {1'b0, NB'(nr)})
          $display("FAIL single_read got=%b/%0d exp=0/%0d", oUNLOAD_BANK, oUNLOAD_ADDR, nr); else n_pass++;
        nr++;
      end
      if (oOUT_VALID === 1'b1) begin
        nv++;
        if (oOUT_LAST === 1'b1) lastv = cyc;
      end
    end
    n_chk++; if (s != w + 2) $display("FAIL single_start_time got=%0d exp=%0d", s, w + 2); else n_pass++;
    n_chk++; if (r0 != s + FHT_CYC + 2) $display("FAIL single_first_read got=%0d exp=%0d", r0, s + FHT_CYC + 2); else n_pass++;
    n_chk++; if (lastv != r0 + NPT - 1 + LAT) $display("FAIL single_last_time got=%0d exp=%0d", lastv, r0 + NPT - 1 + LAT); else n_pass++;
    n_chk++; if (nv != NPT || nr != NPT) $display("FAIL single_counts got=%0d/%0d exp=%0d", nv, nr, NPT); else n_pass++;
    n_chk++; if (starts != 1) $display("FAIL single_start_count got=%0d exp=1", starts); else n_pass++;
  endtask

  task automatic test_streaming();
    int first_wr = -1, wr31 = -1;
    bit fb [0:3];
    do_reset();
    v_in = 1'b1; v_ordy = 1'b1;
    for (int i = 0; i < 1200 && n_rd < 4 * NPT; i++) begin
      if (n_wr >= 4 * NPT) v_in = 1'b0;
      tick();
      n_chk++; if (oIN_READY !== e_ready) $display("FAIL stream_ready cyc=%0d got=%b exp=%b", cyc, oIN_READY, e_ready); else n_pass++;
      n_chk++; if (oLOAD_WE !== e_we || (e_we && {oLOAD_BANK, oLOAD_ADDR} !== {e_ld_bank, e_ld_addr}))
        $display("FAIL stream_load cyc=%0d got=%b %b/%0d exp=%b %b/%0d", cyc, oLOAD_WE, oLOAD_BANK, oLOAD_ADDR, e_we, e_ld_bank, e_ld_addr); else n_pass++;
      n_chk++; if (oRD_EN !== e_rd || (e_rd && {oUNLOAD_BANK, oUNLOAD_ADDR} !== {e_rd_bank, e_rd_addr}))
        $display("FAIL stream_read cyc=%0d got=%b %b/%0d exp=%b %b/%0d", cyc, oRD_EN, oUNLOAD_BANK, oUNLOAD_ADDR, e_rd, e_rd_bank, e_rd_addr); else n_pass++;
      n_chk++; if ({oOUT_VALID, oOUT_LAST} !== {e_vld, e_last})
        $display("FAIL stream_out cyc=%0d got=%b%b exp=%b%b", cyc, oOUT_VALID, oOUT_LAST, e_vld, e_last); else n_pass++;
      if (oFHT_START === 1'b1) begin
        n_chk++; if (oFHT_BANK !== e_st_bank || !e_st_ok)
          $display("FAIL stream_start cyc=%0d got=%b exp=%b loaded=%b", cyc, oFHT_BANK, e_st_bank, e_st_ok); else n_pass++;
      end
      if (oLOAD_WE === 1'b1) begin
        if (n_wr == 1) first_wr = cyc;
        if (n_wr == 2 * NPT) wr31 = cyc;
        if (oLOAD_ADDR == '0 && (n_wr - 1) / NPT < 4) fb[(n_wr - 1) / NPT] = oLOAD_BANK;
      end
    end
    n_chk++; if (wr31 - first_wr != 2 * NPT - 1)
      $display("FAIL stream_no_early_bp got=%0d exp=%0d", wr31 - first_wr, 2 * NPT - 1); else n_pass++;
    n_chk++; if ({fb[0], fb[1], fb[2]} !== 3'b010)
      $display("FAIL stream_bank_seq got=%b exp=010", {fb[0], fb[1], fb[2]}); else n_pass++;
    n_chk++; if (n_rd != 4 * NPT) $display("FAIL stream_drained got=%0d exp=%0d", n_rd, 4 * NPT); else n_pass++;
  endtask

  task automatic test_backpressure();
    int hold = 0, stall_wr = -1;
    bit stalled = 1'b0, resumed = 1'b0;
    do_reset();
    v_in = 1'b1; v_ordy = 1'b0;
    for (int i = 0; i < 400 && n_wr < 3 * NPT; i++) begin
      if (stalled && hold == 80) v_ordy = 1'b1;
      tick();
      n_chk++; if (oIN_READY !== e_ready) $display("FAIL bp_ready cyc=%0d got=%b exp=%b", cyc, oIN_READY, e_ready); else n_pass++;
      n_chk++; if (oLOAD_WE !== e_we || (e_we && {oLOAD_BANK, oLOAD_ADDR} !== {e_ld_bank, e_ld_addr}))
        $display("FAIL bp_load cyc=%0d got=%b %b/%0d exp=%b %b/%0d", cyc, oLOAD_WE, oLOAD_BANK, oLOAD_ADDR, e_we, e_ld_bank, e_ld_addr); else n_pass++;
      n_chk++; if (oRD_EN !== e_rd || (e_rd && {oUNLOAD_BANK, oUNLOAD_ADDR} !== {e_rd_bank, e_rd_addr}))
        $display("FAIL bp_read cyc=%0d got=%b %b/%0d exp=%b %b/%0d", cyc, oRD_EN, oUNLOAD_BANK, oUNLOAD_ADDR, e_rd, e_rd_bank, e_rd_addr); else n_pass++;
      n_chk++; if ({oOUT_VALID, oOUT_LAST} !== {e_vld, e_last})
        $display("FAIL bp_out cyc=%0d got=%b%b exp=%b%b", cyc, oOUT_VALID, oOUT_LAST, e_vld, e_last); else n_pass++;
      if (!stalled && oIN_READY === 1'b0) begin
        stalled = 1'b1; stall_wr = n_wr;
        n_chk++; if ({oLOAD_BANK, oLOAD_ADDR} !== {1'b0, NB'(0)})
          $display("FAIL bp_stall_pos got=%b/%0d exp=0/0", oLOAD_BANK, oLOAD_ADDR); else n_pass++;
      end else if (stalled && !resumed && oLOAD_WE === 1'b1) begin
        resumed = 1'b1;
        n_chk++; if ({oLOAD_BANK, oLOAD_ADDR} !== {1'b0, NB'(0)})
          $display("FAIL bp_resume got=%b/%0d exp=0/0", oLOAD_BANK, oLOAD_ADDR); else n_pass++;
      end
      if (stalled && hold < 80) hold++;
    end
    n_chk++; if (stall_wr != 2 * NPT) $display("FAIL bp_stall_count got=%0d exp=%0d", stall_wr, 2 * NPT); else n_pass++;
    n_chk++; if (n_wr != 3 * NPT) $display("FAIL bp_total_writes got=%0d exp=%0d", n_wr, 3 * NPT); else n_pass++;
  endtask

  task automatic test_timeout();
    int s = -1, starts = 0;
    do_reset();
    normal_core = 1'b0;
    v_in = 1'b1; v_ordy = 1'b1;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (oFHT_START === 1'b1) begin
        starts++;
        if (s < 0) s = cyc;
      end
      if (s >= 0 && cyc == s + TO - 1) begin
        n_chk++; if (oERR !== 1'b0) $display("FAIL to_err_early got=%b exp=0", oERR); else n_pass++;
      end
      if (s >= 0 && cyc == s + TO) begin
        n_chk++; if (oERR !== 1'b1) $display("FAIL to_err_set got=%b exp=1", oERR); else n_pass++;
      end
    end
    n_chk++; if (starts != 1) $display("FAIL to_single_start got=%0d exp=1", starts); else n_pass++;
    n_chk++; if (oERR !== 1'b1) $display("FAIL to_err_sticky got=%b exp=1", oERR); else n_pass++;
    normal_core = 1'b1;
    do_reset();
    tick();
    n_chk++; if (oERR !== 1'b0) $display("FAIL to_err_cleared got=%b exp=0", oERR); else n_pass++;
  endtask

  task automatic test_reset_mid_fht();
    int s = -1;
    bit got_first = 1'b0;
    do_reset();
    v_in = 1'b1; v_ordy = 1'b1;
    for (int i = 0; i < 100 && !(s >= 0 && cyc == s + 6); i++) begin
      tick();
      if (s < 0 && oFHT_START === 1'b1) s = cyc;
    end
    n_chk++; if (iFHT_RDY !== 1'b0 || s < 0) $display("FAIL mid_in_fht got=%b start=%0d exp=0", iFHT_RDY, s); else n_pass++;
    do_reset();
    tick();
    n_chk++; if ({oIN_READY, oLOAD_ADDR} !== {1'b1, NB'(0)})
      $display("FAIL mid_load_state got=%b/%0d exp=1/0", oIN_READY, oLOAD_ADDR); else n_pass++;
    n_chk++; if ({oLOAD_BANK, oFHT_BANK, oUNLOAD_BANK, oFHT_START, oRD_EN, oOUT_VALID, oERR} !== 7'b0)
      $display("FAIL mid_outputs got=%b exp=0000000", {oLOAD_BANK, oFHT_BANK, oUNLOAD_BANK, oFHT_START, oRD_EN, oOUT_VALID, oERR}); else n_pass++;
    v_in = 1'b1;
    for (int i = 0; i < 60 && n_start == 0; i++) begin
      tick();
      if (!got_first && oLOAD_WE === 1'b1) begin
        got_first = 1'b1;
        n_chk++; if ({oLOAD_BANK, oLOAD_ADDR} !== {1'b0, NB'(0)})
          $display("FAIL mid_first_write got=%b/%0d exp=0/0", oLOAD_BANK, oLOAD_ADDR); else n_pass++;
      end
      if (oFHT_START === 1'b1) begin
        n_chk++; if (oFHT_BANK !== 1'b0) $display("FAIL mid_restart_bank got=%b exp=0", oFHT_BANK); else n_pass++;
      end
    end
    n_chk++; if (n_start != 1) $display("FAIL mid_restart got=%0d exp=1", n_start); else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 900; i++) begin
      v_in   = (i < 650) && ($urandom_range(3) != 0);
      v_ordy = (i >= 650) || ($urandom_range(2) != 0);
      tick();
      n_chk++; if (oIN_READY !== e_ready) $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, oIN_READY, e_ready); else n_pass++;
      n_chk++; if (oLOAD_WE !== e_we || (e_we && {oLOAD_BANK, oLOAD_ADDR} !== {e_ld_bank, e_ld_addr}))
        $display("FAIL rnd_load cyc=%0d got=%b %b/%0d exp=%b %b/%0d", cyc, oLOAD_WE, oLOAD_BANK, oLOAD_ADDR, e_we, e_ld_bank, e_ld_addr); else n_pass++;
      n_chk++; if (oRD_EN !== e_rd || (e_rd && {oUNLOAD_BANK, oUNLOAD_ADDR} !== {e_rd_bank, e_rd_addr}))
        $display("FAIL rnd_read cyc=%0d got=%b %b/%0d exp=%b %b/%0d", cyc, oRD_EN, oUNLOAD_BANK, oUNLOAD_ADDR, e_rd, e_rd_bank, e_rd_addr); else n_pass++;
      n_chk++; if ({oOUT_VALID, oOUT_LAST} !== {e_vld, e_last})
        $display("FAIL rnd_out cyc=%0d got=%b%b exp=%b%b", cyc, oOUT_VALID, oOUT_LAST, e_vld, e_last); else n_pass++;
      if (oFHT_START === 1'b1) begin
        n_chk++; if (oFHT_BANK !== e_st_bank || !e_st_ok)
          $display("FAIL rnd_start cyc=%0d got=%b exp=%b loaded=%b", cyc, oFHT_BANK, e_st_bank, e_st_ok); else n_pass++;
      end
    end
    n_chk++; if (n_rd != (n_wr / NPT) * NPT)
      $display("FAIL rnd_drain got=%0d exp=%0d", n_rd, (n_wr / NPT) * NPT); else n_pass++;
  endtask

  initial begin
    iRESET = 1'b1; iIN_VALID = 1'b0; iOUT_READY = 1'b0; iFHT_RDY = 1'b1;
    test_reset();
    test_single_frame();
    test_streaming();
    test_backpressure();
    test_timeout();
    test_reset_mid_fht();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
